// File: rtl/tas_pkg.sv
// Shared types and defaults for the temperature averaging RAM writer.
package tas_pkg;

  typedef enum logic [2:0] {
    FETCH,
    CAPTURE,
    AVG,
    WRITE,
    POST
  } wr_state_t;

  localparam int TAS_DATA_W = 8;
  localparam int TAS_ADDR_W = 11;
  localparam int TAS_SAMPLES = 4;
  localparam logic [TAS_ADDR_W-1:0] TAS_ADDR_START = 11'h7FF;
  localparam int TAS_SUM_W = TAS_DATA_W + $clog2(TAS_SAMPLES) + 1;

endpackage

// File: rtl/tas_avg_accum.sv
// Group accumulator: sums SAMPLES bytes and presents their average.
// Defining TAS_ROUND_EN makes the average round half up instead of truncating.
module tas_avg_accum
  import tas_pkg::*;
#(
  parameter int DATA_W  = TAS_DATA_W,
  parameter int SAMPLES = TAS_SAMPLES
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic              clear,
  input  logic              add,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] avg,
  output logic              last
);

  localparam int SHIFT = $clog2(SAMPLES);
  localparam int SUM_W = DATA_W + SHIFT + 1;
  localparam int CNT_W = SHIFT;

  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt;

  function automatic logic [DATA_W-1:0] scale(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] t;
`ifdef TAS_ROUND_EN
    t = s + SUM_W'(SAMPLES / 2);
`else
    t = s;
`endif
    return DATA_W'(t >> SHIFT);
  endfunction

  always_ff @(posedge clk_2) begin
    if (reset || clear) begin
      sum <= '0;
      cnt <= '0;
    end else if (add) begin
      sum <= sum + SUM_W'(data);
      cnt <= cnt + 1'b1;
    end
  end

  assign avg  = scale(sum);
  assign last = (cnt == CNT_W'(SAMPLES - 1));

endmodule

// File: rtl/tas_ram_writer.sv
// Drains the CDC FIFO, averages each group of SAMPLES bytes and writes the
// result downward through RAM. Optional rounding via the TAS_ROUND_EN macro.
module tas_ram_writer
  import tas_pkg::*;
#(
  parameter int                DATA_W     = TAS_DATA_W,
  parameter int                ADDR_W     = TAS_ADDR_W,
  parameter int                SAMPLES    = TAS_SAMPLES,
  parameter logic [ADDR_W-1:0] ADDR_START = ADDR_W'(TAS_ADDR_START)
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              ram_wr_n,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr
);

  wr_state_t         state;
  wr_state_t         state_next;
  logic              acc_add;
  logic              acc_clear;
  logic              acc_last;
  logic [DATA_W-1:0] acc_avg;

  tas_avg_accum #(
    .DATA_W (DATA_W),
    .SAMPLES(SAMPLES)
  ) u_accum (
    .clk_2(clk_2),
    .reset(reset),
    .clear(acc_clear),
    .add  (acc_add),
    .data (fifo_data),
    .avg  (acc_avg),
    .last (acc_last)
  );

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Reset gates the read strobe so no FIFO byte is lost while held in reset.
  always_comb begin
    state_next = state;
    fifo_rd    = 1'b0;
    acc_add    = 1'b0;
    acc_clear  = 1'b0;
    case (state)
      FETCH: begin
        fifo_rd = !fifo_empty && !reset;
        if (fifo_rd) state_next = CAPTURE;
      end
      CAPTURE: begin
        acc_add    = 1'b1;
        state_next = acc_last ? AVG : FETCH;
      end
      AVG: begin
        acc_clear  = 1'b1;
        state_next = WRITE;
      end
      WRITE:   state_next = POST;
      POST:    state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Strobe is registered: WRITE always follows AVG, so it is low exactly in WRITE.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      ram_wr_n <= 1'b1;
      ram_data <= '0;
      ram_addr <= ADDR_START;
    end else begin
      ram_wr_n <= (state != AVG);
      if (state == AVG) ram_data <= acc_avg;
      if (state == POST) ram_addr <= (ram_addr == '0) ? ADDR_START : ram_addr - 1'b1;
    end
  end

endmodule

// File: tb/tb_tas_ram_writer.sv
// Randomised bench for tas_ram_writer against a queue-based averaging model.
`timescale 1ns/1ps
module tb_tas_ram_writer;

  logic        clk_2 = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd;
  logic        ram_wr_n;
  logic [7:0]  ram_data;
  logic [10:0] ram_addr;

  always #250 clk_2 = ~clk_2;

  tas_ram_writer dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .ram_wr_n  (ram_wr_n),
    .ram_data  (ram_data),
    .ram_addr  (ram_addr)
  );

  int checks = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model and reference model
  logic [7:0]  byte_q[$];
  int          part[$];
  logic [10:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  logic [10:0] maddr = 11'h7FF;
  bit          stall = 1'b0;

  function automatic void upd_empty();
    fifo_empty = stall || (byte_q.size() == 0);
  endfunction

  task automatic push(input logic [7:0] b);
    int s;
    byte_q.push_back(b);
    part.push_back(int'(b));
    if (part.size() == 4) begin
      s = 0;
      foreach (part[i]) s += part[i];
`ifdef TAS_ROUND_EN
      exp_data.push_back(8'((s + 2) / 4));
`else
      exp_data.push_back(8'(s / 4));
`endif
      exp_addr.push_back(maddr);
      maddr = (maddr == 11'd0) ? 11'h7FF : maddr - 11'd1;
      part.delete();
    end
    upd_empty();
  endtask

  always @(posedge clk_2) begin : fifo_side
    logic taken;
    taken = fifo_rd;
    #1;
    if (taken && byte_q.size() > 0) fifo_data = byte_q.pop_front();
    else fifo_data = 8'($urandom);
    upd_empty();
  end

  // Monitor: strobe shape, address/data per write, read-while-empty
  logic        rst_at_edge = 1'b1;
  logic        prev_wr_n = 1'b1;
  logic [10:0] prev_addr = 11'h7FF;
  logic [10:0] s_addr;
  logic [7:0]  s_data;
  bit          post_chk = 1'b0;
  int          rd_pulses = 0;
  int          writes = 0;

  always @(posedge clk_2) rst_at_edge = reset;

  always @(negedge clk_2) begin
    if (fifo_rd) rd_pulses++;
    if (fifo_empty) chk("rd_while_empty", 32'(fifo_rd), 0);
    if (post_chk && !rst_at_edge) begin
      chk("hold_addr", 32'(ram_addr), 32'(s_addr));
      chk("hold_data", 32'(ram_data), 32'(s_data));
    end
    post_chk = 1'b0;
    if (ram_wr_n === 1'b0) begin
      writes++;
      chk("strobe_width", 32'(prev_wr_n), 1);
      chk("setup_addr", 32'(prev_addr), 32'(ram_addr));
      if (exp_addr.size() == 0) begin
        chk("unexpected_write", 0, 1);
      end else begin
        chk("wr_addr", 32'(ram_addr), 32'(exp_addr.pop_front()));
        chk("wr_data", 32'(ram_data), 32'(exp_data.pop_front()));
      end
      s_addr = ram_addr;
      s_data = ram_data;
      post_chk = 1'b1;
    end
    prev_wr_n = ram_wr_n;
    prev_addr = ram_addr;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while ((exp_addr.size() != 0 || byte_q.size() != 0) && k < budget) begin
      @(negedge clk_2);
      k++;
    end
    chk("drain_timeout", 32'(k < budget), 1);
    cyc(3);
  endtask

  task automatic do_reset();
    @(negedge clk_2);
    reset = 1'b1;
    byte_q.delete();
    part.delete();
    exp_addr.delete();
    exp_data.delete();
    maddr = 11'h7FF;
    upd_empty();
    cyc(2);
    chk("rst_addr", 32'(ram_addr), 32'h7FF);
    chk("rst_data", 32'(ram_data), 0);
    chk("rst_wr_n", 32'(ram_wr_n), 1);
    reset = 1'b0;
  endtask

  initial begin
    int r0, w0, k;
    logic [7:0] d0;

    // Reset with a byte waiting: no read may be issued
    reset = 1'b1;
    byte_q.push_back(8'h55);
    upd_empty();
    cyc(3);
    chk("rst_fifo_rd", 32'(fifo_rd), 0);
    chk("rst_addr0", 32'(ram_addr), 32'h7FF);
    chk("rst_data0", 32'(ram_data), 0);
    chk("rst_wr_n0", 32'(ram_wr_n), 1);
    byte_q.delete();
    upd_empty();
    reset = 1'b0;
    cyc(2);

    // Basic group 10,20,30,40
    r0 = rd_pulses;
    w0 = writes;
    push(8'd10); push(8'd20); push(8'd30); push(8'd40);
    wait_done(100);
    chk("basic_rd_count", 32'(rd_pulses - r0), 4);
    chk("basic_writes", 32'(writes - w0), 1);
    chk("basic_data", 32'(ram_data), 25);
    chk("basic_next_addr", 32'(ram_addr), 32'h7FE);

    // Rounding boundary and maximum value
    push(8'd1); push(8'd2); push(8'd2); push(8'd2);
    wait_done(100);
`ifdef TAS_ROUND_EN
    chk("round_1222", 32'(ram_data), 2);
`else
    chk("trunc_1222", 32'(ram_data), 1);
`endif
    for (int i = 0; i < 4; i++) push(8'd255);
    wait_done(100);
    chk("max_255", 32'(ram_data), 255);

    // Empty FIFO mid-group stalls with the partial sum kept
    push(8'($urandom)); push(8'($urandom));
    cyc(10);
    d0 = ram_data;
    r0 = rd_pulses;
    w0 = writes;
    cyc(50);
    chk("stall_rd", 32'(rd_pulses - r0), 0);
    chk("stall_writes", 32'(writes - w0), 0);
    chk("stall_data", 32'(ram_data), 32'(d0));
    stall = 1'b1;
    push(8'($urandom)); push(8'($urandom));
    cyc(20);
    chk("stall_flag_rd", 32'(rd_pulses - r0), 0);
    stall = 1'b0;
    upd_empty();
    wait_done(100);
    chk("stall_done_writes", 32'(writes - w0), 1);

    // Random groups
    w0 = writes;
    for (int g = 0; g < 40; g++)
      for (int i = 0; i < 4; i++) push(8'($urandom));
    wait_done(1000);
    chk("rand_writes", 32'(writes - w0), 40);

    // Reset mid-group discards the partial group
    for (int i = 0; i < 3; i++) push(8'($urandom));
    cyc(10);
    do_reset();
    w0 = writes;
    for (int i = 0; i < 4; i++) push(8'd100);
    wait_done(100);
    chk("partial_writes", 32'(writes - w0), 1);
    chk("partial_data", 32'(ram_data), 100);
    chk("partial_next_addr", 32'(ram_addr), 32'h7FE);

    // Reset during the strobe cycle
    for (int i = 0; i < 4; i++) push(8'($urandom));
    k = 0;
    while (ram_wr_n !== 1'b0 && k < 40) begin
      @(negedge clk_2);
      k++;
    end
    chk("strobe_seen", 32'(k < 40), 1);
    reset = 1'b1;
    @(negedge clk_2);
    chk("abort_wr_n", 32'(ram_wr_n), 1);
    chk("abort_addr", 32'(ram_addr), 32'h7FF);
    chk("abort_fifo_rd", 32'(fifo_rd), 0);
    do_reset();

    // Full address wrap: 2049 groups of 7
    w0 = writes;
    for (int i = 0; i < 2049 * 4; i++) push(8'd7);
    wait_done(30000);
    chk("wrap_writes", 32'(writes - w0), 2049);
    chk("wrap_next_addr", 32'(ram_addr), 32'h7FE);
    chk("wrap_data", 32'(ram_data), 7);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
